// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - buffers A/B operand vectors, streams them to a MAC, returns the dot product
// Optional feature macro: SEQ_ERR_ABORT_EN (stop streaming as soon as the MAC reports overflow)
module mac_operand_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
    parameter int MAX_LEN     = 16,
    parameter int LEN_WIDTH   = $clog2(MAX_LEN+1),
    parameter int ADDR_WIDTH  = $clog2(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_a,
    input  logic [DATA_WIDTH-1:0]  wr_b,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   len,
    output logic                   busy,
    output logic                   mac_clr,
    output logic                   mac_running,
    output logic [DATA_WIDTH-1:0]  mac_in1,
    output logic [DATA_WIDTH-1:0]  mac_in2,
    input  logic [ACCUM_WIDTH-1:0] mac_total,
    input  logic                   mac_err,
    output logic [ACCUM_WIDTH-1:0] result,
    output logic                   result_err,
    output logic                   result_valid,
    input  logic                   result_ready
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic                   mac_clr_q, mac_clr_d;
    logic                   mac_running_q, mac_running_d;
    logic [DATA_WIDTH-1:0]  mac_in1_q, mac_in1_d;
    logic [DATA_WIDTH-1:0]  mac_in2_q, mac_in2_d;
    logic [ACCUM_WIDTH-1:0] result_q, result_d;
    logic                   result_err_q, result_err_d;
    logic                   result_valid_q, result_valid_d;
    logic                   abort;

    logic [DATA_WIDTH-1:0]  mem_a_q [MAX_LEN];
    logic [DATA_WIDTH-1:0]  mem_b_q [MAX_LEN];

`ifdef SEQ_ERR_ABORT_EN
    assign abort = mac_err;
`else
    assign abort = 1'b0;
`endif

    assign busy = (state_q == S_CLEAR) || (state_q == S_STREAM) || (state_q == S_DRAIN);

    // Operand buffer is deliberately not reset so vectors survive a run abort.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem_a_q[wr_addr] <= wr_a;
            mem_b_q[wr_addr] <= wr_b;
        end
    end

    // idx_q always names the next pair to present; pair 0 is issued from CLEAR.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        idx_d          = idx_q;
        mac_clr_d      = 1'b0;
        mac_running_d  = 1'b0;
        mac_in1_d      = '0;
        mac_in2_d      = '0;
        result_d       = result_q;
        result_err_d   = result_err_q;
        result_valid_d = result_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    mac_clr_d = 1'b1;
                    len_d     = (len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len;
                end
            end
            S_CLEAR: begin
                idx_d = '0;
                if (len_q == '0) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d       = S_STREAM;
                    mac_running_d = 1'b1;
                    mac_in1_d     = mem_a_q[0];
                    mac_in2_d     = mem_b_q[0];
                    idx_d         = LEN_WIDTH'(1);
                end
            end
            S_STREAM: begin
                if ((idx_q == len_q) || abort) begin
                    state_d = S_DRAIN;
                end else begin
                    mac_running_d = 1'b1;
                    mac_in1_d     = mem_a_q[idx_q[ADDR_WIDTH-1:0]];
                    mac_in2_d     = mem_b_q[idx_q[ADDR_WIDTH-1:0]];
                    idx_d         = idx_q + LEN_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                state_d        = S_DONE;
                result_d       = mac_total;
                result_err_d   = mac_err;
                result_valid_d = 1'b1;
            end
            S_DONE: begin
                if (result_ready) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            idx_q          <= '0;
            mac_clr_q      <= 1'b0;
            mac_running_q  <= 1'b0;
            mac_in1_q      <= '0;
            mac_in2_q      <= '0;
            result_q       <= '0;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            mac_clr_q      <= mac_clr_d;
            mac_running_q  <= mac_running_d;
            mac_in1_q      <= mac_in1_d;
            mac_in2_q      <= mac_in2_d;
            result_q       <= result_d;
            result_err_q   <= result_err_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign mac_clr      = mac_clr_q;
    assign mac_running  = mac_running_q;
    assign mac_in1      = mac_in1_q;
    assign mac_in2      = mac_in2_q;
    assign result       = result_q;
    assign result_err   = result_err_q;
    assign result_valid = result_valid_q;

endmodule
